seq_bcd_display: RTL and testbench

Downstream consumer of the sequence generator's 16-bit current number and its new-number strobe. On each strobe, the block converts the binary value to 5 BCD digits with an iterative double-dabble, one iteration per clock. It then drives a time-multiplexed 5-digit common-cathode 7-segment display from the latched result. The block sits between the sequence generator outputs and the board's display pins.

---
 rtl/seq_disp_pkg.sv | 24 ++
 rtl/seq_bcd_display_if.sv | 17 +
 rtl/bin2bcd_dd.sv | 55 +++++
 rtl/seq_bcd_display.sv | 82 ++++++++
 tb/tb_seq_bcd_display.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/seq_disp_pkg.sv
// seq_disp_pkg: shared FSM state, sizes and 7-segment decode for the BCD display path.
package seq_disp_pkg;
   localparam int NUM_DIGITS = 5;
   localparam int BCD_W      = 20;

   typedef enum logic {IDLE, CONV} state_t;

   // Segments {g,f,e,d,c,b,a}; codes 10-15 cannot come out of the converter and decode dark.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction
endpackage

// File: rtl/seq_bcd_display_if.sv
// seq_bcd_display_if: number/strobe inputs and display/BCD outputs of the display block.
interface seq_bcd_display_if;
   import seq_disp_pkg::*;
   logic [15:0]      value_in;
   logic             load;
   logic             blank_lz;
   logic [6:0]       seg;
   logic [4:0]       digit_sel;
   logic             busy;
   logic             bcd_valid;
   logic [BCD_W-1:0] bcd_out;

   modport master (output value_in, load, blank_lz,
                   input  seg, digit_sel, busy, bcd_valid, bcd_out);
   modport slave  (input  value_in, load, blank_lz,
                   output seg, digit_sel, busy, bcd_valid, bcd_out);
endinterface

// File: rtl/bin2bcd_dd.sv
// bin2bcd_dd: iterative double-dabble, 16 add-3/shift steps, one per enabled clock.
module bin2bcd_dd
   import seq_disp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_ena,
   input  logic             i_load,
   input  logic [15:0]      i_value,
   output logic             o_busy,
   output logic             o_done,
   output logic [BCD_W-1:0] o_bcd
);
   state_t      r_state, w_state_nx;
   logic [35:0] r_sr, w_sr_nx, w_adj, w_shl;
   logic [3:0]  r_iter, w_iter_nx;

   always_comb begin
      w_adj = r_sr;
      for (int i = 0; i < NUM_DIGITS; i++)
         w_adj[16+4*i +: 4] = r_sr[16+4*i +: 4] >= 4'd5 ? r_sr[16+4*i +: 4] + 4'd3 : r_sr[16+4*i +: 4];
   end

   assign w_shl  = w_adj << 1;
   assign o_busy = r_state == CONV;
   assign o_done = o_busy && r_iter == 4'd15;
   assign o_bcd  = w_shl[35:16];

   // A load accepted on the final step restarts straight away, giving back-to-back conversions.
   always_comb begin
      w_state_nx = r_state;
      w_sr_nx    = r_sr;
      w_iter_nx  = r_iter;
      if (i_load && (!o_busy || o_done)) begin
         w_state_nx = CONV;
         w_sr_nx    = {20'd0, i_value};
         w_iter_nx  = 4'd0;
      end else if (o_busy) begin
         w_state_nx = o_done ? IDLE : CONV;
         w_sr_nx    = w_shl;
         w_iter_nx  = r_iter + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= IDLE;
         r_sr    <= '0;
         r_iter  <= '0;
      end else if (i_ena) begin
         r_state <= w_state_nx;
         r_sr    <= w_sr_nx;
         r_iter  <= w_iter_nx;
      end
endmodule

// File: rtl/seq_bcd_display.sv
// seq_bcd_display: converts strobed binary numbers to BCD and scans them onto a
// 5-digit multiplexed 7-segment display with optional leading-zero blanking.
module seq_bcd_display
   import seq_disp_pkg::*;
#(
   parameter int SCAN_DIV = 1024
)(
   input logic               clk,
   input logic               rst_n,
   input logic               ena,
   seq_bcd_display_if.slave  bus
);
   localparam int CW = $clog2(SCAN_DIV);

   logic                  w_busy, w_done, w_start, w_wrap, w_blank;
   logic [15:0]           w_start_val, r_pend_val;
   logic                  r_pend, r_valid;
   logic [BCD_W-1:0]      w_bcd, r_bcd;
   logic [CW-1:0]         r_cnt;
   logic [2:0]            r_idx, w_nidx;
   logic [4:0]            r_sel;
   logic [6:0]            r_seg;
   logic [3:0]            w_nib;
   logic [NUM_DIGITS-1:0] w_lz;

   // A pending value starts as soon as the converter can take it; a fresh load in IDLE wins.
   assign w_start     = w_busy ? (w_done && r_pend) : (bus.load || r_pend);
   assign w_start_val = (!w_busy && bus.load) ? bus.value_in : r_pend_val;

   bin2bcd_dd u_dd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_ena   (ena),
      .i_load  (w_start),
      .i_value (w_start_val),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_bcd   (w_bcd)
   );

   always_comb begin
      w_lz    = '0;
      w_lz[4] = r_bcd[19:16] == 4'd0;
      for (int i = 3; i >= 0; i--)
         w_lz[i] = r_bcd[4*i +: 4] == 4'd0 && w_lz[i+1];
   end

   assign w_wrap  = r_cnt == CW'(SCAN_DIV - 1);
   assign w_nidx  = r_idx == 3'd4 ? 3'd0 : r_idx + 3'd1;
   assign w_nib   = 4'(r_bcd >> {w_nidx, 2'b00});
   assign w_blank = bus.blank_lz && w_nidx != 3'd0 && w_lz[w_nidx];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_pend     <= 1'b0;
         r_pend_val <= '0;
         r_bcd      <= '0;
         r_valid    <= 1'b0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_sel      <= 5'b00001;
         r_seg      <= 7'h3F;
      end else if (ena) begin
         r_pend     <= (w_busy && bus.load) || (r_pend && !w_start);
         r_pend_val <= (w_busy && bus.load) ? bus.value_in : r_pend_val;
         r_bcd      <= w_done ? w_bcd : r_bcd;
         r_valid    <= w_done;
         r_cnt      <= w_wrap ? '0 : r_cnt + 1'b1;
         // Select and segments move on the same edge so no digit ever shows a neighbour's pattern.
         if (w_wrap) begin
            r_idx <= w_nidx;
            r_sel <= 5'd1 << w_nidx;
            r_seg <= w_blank ? 7'h00 : seg7(w_nib);
         end
      end

   assign bus.busy      = w_busy;
   assign bus.bcd_valid = r_valid;
   assign bus.bcd_out   = r_bcd;
   assign bus.digit_sel = r_sel;
   assign bus.seg       = r_seg;
endmodule

// File: tb/tb_seq_bcd_display.sv
// tb_seq_bcd_display: directed stimulus with queued expectations for BCD results and scanned segments.
module tb_seq_bcd_display;
   import seq_disp_pkg::*;
   localparam int SD = 8;

   logic clk = 0, rst_n = 0, ena = 1;
   int   cyc = 0, checks = 0, errors = 0;

   seq_bcd_display_if bus();
   seq_bcd_display #(.SCAN_DIV(SD)) dut (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [19:0] bcd; int at;} bexp_t;
   typedef struct {logic [4:0] sel; logic [6:0] seg;} sexp_t;
   bexp_t bq[$];
   sexp_t sq[$];
   logic [4:0] prev_sel = 5'b00001;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      bexp_t b;
      sexp_t s;
      if (bus.bcd_valid) begin
         if (bq.size() == 0) chk("spurious_bcd_valid", bus.bcd_valid, 0);
         else begin
            b = bq.pop_front();
            chk("bcd_out", bus.bcd_out, b.bcd);
            chk("valid_cycle", cyc, b.at);
         end
      end
      if (sq.size() != 0 && bus.digit_sel != prev_sel && bus.digit_sel == sq[0].sel) begin
         s = sq.pop_front();
         chk("seg", bus.seg, s.seg);
      end
      prev_sel <= bus.digit_sel;
   end

   task automatic do_load(input logic [15:0] v, output int k);
      bus.value_in = v;
      bus.load = 1;
      k = cyc + 1;
      @(negedge clk);
      bus.load = 0;
   endtask

   task automatic expect_bcd(input logic [19:0] b, input int at);
      bq.push_back('{b, at});
   endtask

   task automatic scan_expect(input logic [6:0] s0, s1, s2, s3, s4);
      sq.push_back('{5'b00010, s1});
      sq.push_back('{5'b00100, s2});
      sq.push_back('{5'b01000, s3});
      sq.push_back('{5'b10000, s4});
      sq.push_back('{5'b00001, s0});
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n && (bq.size() != 0 || sq.size() != 0); i++) @(negedge clk);
      if (bq.size() != 0 || sq.size() != 0) begin
         chk("drain_timeout", bq.size() + sq.size(), 0);
         bq.delete();
         sq.delete();
      end
   endtask

   initial begin : stim
      int k, k2, frz;
      logic [4:0] sel0;
      bus.load = 0;
      bus.value_in = 0;
      bus.blank_lz = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.bcd_valid, 0);
      chk("rst_bcd", bus.bcd_out, 0);
      chk("rst_seg", bus.seg, 7'h3F);
      chk("rst_sel", bus.digit_sel, 5'b00001);
      scan_expect(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
      drain(200);

      @(negedge clk);
      do_load(16'd12345, k);
      expect_bcd(20'h12345, k + 16);
      chk("busy_conv", bus.busy, 1);
      drain(100);
      chk("busy_done", bus.busy, 0);
      scan_expect(7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
      drain(200);

      do_load(16'd65535, k);
      expect_bcd(20'h65535, k + 16);
      drain(100);
      scan_expect(7'h6D, 7'h4F, 7'h6D, 7'h6D, 7'h7D);
      drain(200);

      bus.blank_lz = 1;
      do_load(16'd0, k);
      expect_bcd(20'h00000, k + 16);
      drain(100);
      scan_expect(7'h3F, 7'h00, 7'h00, 7'h00, 7'h00);
      drain(200);

      do_load(16'd100, k);
      expect_bcd(20'h00100, k + 16);
      expect_bcd(20'h00042, k + 32);
      repeat (2) @(negedge clk);
      do_load(16'd7, k2);
      do_load(16'd42, k2);
      drain(100);
      scan_expect(7'h5B, 7'h66, 7'h00, 7'h00, 7'h00);
      drain(200);

      bus.blank_lz = 0;
      do_load(16'd999, k);
      expect_bcd(20'h00999, k + 66);
      repeat (4) @(negedge clk);
      ena = 0;
      sel0 = bus.digit_sel;
      bus.value_in = 16'd1234;
      bus.load = 1;
      @(negedge clk);
      bus.load = 0;
      frz = 0;
      repeat (49) begin
         @(negedge clk);
         if (bus.digit_sel != sel0 || bus.busy !== 1'b1) frz++;
      end
      chk("ena_freeze", frz, 0);
      ena = 1;
      @(negedge clk);
      chk("busy_after_ena", bus.busy, 1);
      drain(100);
      scan_expect(7'h6F, 7'h6F, 7'h6F, 7'h3F, 7'h3F);
      drain(200);

      do_load(16'd555, k);
      repeat (7) @(negedge clk);
      rst_n = 0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_bcd", bus.bcd_out, 0);
      chk("abort_sel", bus.digit_sel, 5'b00001);
      chk("abort_seg", bus.seg, 7'h3F);
      @(negedge clk);
      rst_n = 1;
      repeat (40) @(negedge clk);
      chk("bcd_after_abort", bus.bcd_out, 0);
      chk("bq_empty", bq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
